expr_ci: RTL and testbench

- Nios II multicycle custom-instruction responder that fronts the existing fixed-latency `expr` floating-point pipeline.
- Accepts an opcode and an IEEE-754 single operand from the CPU and holds `x` stable for the pipeline's latency window.
- Captures `result` at the exact completion cycle and returns it with a one-cycle `done` pulse.
- Also keeps a sticky last-result register and a completed-operation counter, readable by opcode.

---
 rtl/expr_pkg.sv | 16 +
 rtl/expr_ci_expr.sv | 26 ++
 rtl/expr_ci.sv | 96 +++++++++
 tb/tb_expr_ci.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared opcodes, FSM encodings and default pipeline latency for the expr
// custom-instruction responder.
package expr_pkg;

    localparam logic [1:0] OP_EVAL       = 2'd0;
    localparam logic [1:0] OP_READ_LAST  = 2'd1;
    localparam logic [1:0] OP_READ_COUNT = 2'd2;
    localparam logic [1:0] OP_CLEAR      = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int EXPR_LATENCY = 16;

endpackage

// File: rtl/expr_ci_expr.sv
// Behavioural model of the fixed-latency expr pipeline: same ports and latency
// as the real core, computing 2*x by bumping the exponent field.
module expr #(
    parameter int LATENCY = expr_pkg::EXPR_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x,
    output logic [31:0] result
);

    logic [31:0] pipe_q [LATENCY];

    // NOTE: the stages are reset so a freshly released pipeline never presents stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {x[31], x[30:23] + 8'd1, x[22:0]};
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LATENCY-1];

endmodule

// File: rtl/expr_ci.sv
// Nios II multicycle custom instruction wrapping the expr pipeline, with a
// sticky last-result register and a completed-operation counter.
module expr_ci
    import expr_pkg::*;
#(
    parameter int LATENCY = EXPR_LATENCY,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic        busy
);

    // Pipeline output is valid once x_q has been held for LATENCY edges.
    localparam logic [7:0] LAT_END = 8'(LATENCY);

    logic [1:0]       state_q, state_d;
    logic [31:0]      x_q, last_q, resp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       lat_q;
    logic             busy_q;
    logic [31:0]      expr_result;

    expr #(.LATENCY(LATENCY)) u_expr (
        .clk    (clk),
        .reset  (~reset),
        .x      (x_q),
        .result (expr_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (n == OP_EVAL) ? ST_RUN : ST_RESP;
            ST_RUN:  if (lat_q == LAT_END) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            last_q  <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (n)
                            OP_EVAL: begin
                                x_q    <= dataa;
                                lat_q  <= '0;
                                busy_q <= 1'b1;
                            end
                            OP_READ_LAST:  resp_q <= last_q;
                            OP_READ_COUNT: resp_q <= 32'(cnt_q);
                            default: begin
                                resp_q <= '0;
                                last_q <= '0;
                                cnt_q  <= '0;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    lat_q <= lat_q + 8'd1;
                    if (lat_q == LAT_END) begin
                        resp_q <= expr_result;
                        last_q <= expr_result;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign done   = (state_q == ST_RESP);
    assign result = done ? resp_q : 32'h0;
    assign busy   = busy_q;

endmodule

// File: tb/tb_expr_ci.sv
// Directed self-checking bench for expr_ci: latency, reads, clear, clock-enable
// stalls, ignored starts and mid-operation reset.
module tb_expr_ci;
    import expr_pkg::*;

    localparam int LAT = 16;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_en = 1'b1;
    logic        start  = 1'b0;
    logic [1:0]  n      = 2'd0;
    logic [31:0] dataa  = '0;
    logic        done;
    logic [31:0] result;
    logic        busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int pause_at  = 0;
    int pause_len = 0;
    bit spur      = 1'b0;

    always #5 clk = ~clk;

    expr_ci #(.LATENCY(LAT), .CNT_W(16)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1;
        n     = op;
        dataa = d;
    endtask

    // Counts negedges after the sampling edge until done; busy_lo counts low-busy cycles.
    task automatic wait_done(output int cyc, output logic [31:0] res, output int busy_lo);
        cyc = 0; res = '0; busy_lo = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!busy) busy_lo++;
            if (done) begin
                res = result;
                break;
            end
            clk_en = !(pause_len > 0 && cyc >= pause_at && cyc < pause_at + pause_len);
            if (spur && (cyc == 3 || cyc == 9)) begin
                start = 1'b1;
                n     = OP_READ_LAST;
            end
        end
        clk_en = 1'b1;
        start  = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                         input int exp_cyc, input logic [31:0] exp_res, input int exp_busy_lo);
        int          cyc, busy_lo;
        logic [31:0] res;
        issue(op, d);
        wait_done(cyc, res, busy_lo);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_busy_low"}, busy_lo, exp_busy_lo);
    endtask

    task automatic no_done(input string tag, input int ncyc);
        int seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;

        do_op("eval_half", OP_EVAL, 32'h3f000000, LAT + 2, 32'h3f800000, 0);
        no_done("eval_half_single_done", 4);
        do_op("read_last", OP_READ_LAST, 32'hdeadbeef, 1, 32'h3f800000, 1);
        do_op("read_count", OP_READ_COUNT, 32'h0, 1, 32'h00000001, 1);

        do_op("clear", OP_CLEAR, 32'h0, 1, 32'h0, 1);
        do_op("read_last_clr", OP_READ_LAST, 32'h0, 1, 32'h0, 1);
        do_op("read_count_clr", OP_READ_COUNT, 32'h0, 1, 32'h0, 1);

        pause_at = 5; pause_len = 3;
        do_op("eval_pause", OP_EVAL, 32'h3fc00000, LAT + 5, 32'h40400000, 0);
        pause_len = 0;

        spur = 1'b1;
        do_op("eval_spur", OP_EVAL, 32'h3f000000, LAT + 2, 32'h3f800000, 0);
        spur = 1'b0;
        no_done("spur_single_done", 6);
        do_op("read_count_2", OP_READ_COUNT, 32'h0, 1, 32'h00000002, 1);

        issue(OP_EVAL, 32'h40000000);
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_done("abort_no_done", LAT + 6);

        do_op("read_last_rst", OP_READ_LAST, 32'h0, 1, 32'h0, 1);
        do_op("read_count_rst", OP_READ_COUNT, 32'h0, 1, 32'h0, 1);
        do_op("eval_two", OP_EVAL, 32'h40000000, LAT + 2, 32'h40800000, 0);
        do_op("read_last_two", OP_READ_LAST, 32'h0, 1, 32'h40800000, 1);
        do_op("read_count_two", OP_READ_COUNT, 32'h0, 1, 32'h00000001, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
